// File: rtl/uart_rx_ctrl_fsm_if.sv
// uart_rx_ctrl_fsm_if: line, counter, checker and strobe signals of the UART RX controller.
// master = controller side, slave = line/datapath side.
interface uart_rx_ctrl_fsm_if #(
  parameter int PRESC_W  = 5,
  parameter int BITCNT_W = 4
);
  logic                RX_IN;
  logic [PRESC_W-1:0]  Prescale;
  logic                PAR_EN;
  logic [PRESC_W-1:0]  edge_cnt;
  logic [BITCNT_W-1:0] bit_cnt;
  logic                strt_glitch;
  logic                par_err;
  logic                stp_err;
  logic                enable;
  logic                cnt_clr;
  logic                data_samp_en;
  logic                strt_chk_en;
  logic                deser_en;
  logic                par_chk_en;
  logic                stp_chk_en;
  logic                data_valid;
  logic                frame_err;
  logic                busy;

  modport master (
    input  RX_IN, Prescale, PAR_EN, edge_cnt, bit_cnt,
    input  strt_glitch, par_err, stp_err,
    output enable, cnt_clr, data_samp_en,
    output strt_chk_en, deser_en, par_chk_en, stp_chk_en,
    output data_valid, frame_err, busy
  );

  modport slave (
    output RX_IN, Prescale, PAR_EN, edge_cnt, bit_cnt,
    output strt_glitch, par_err, stp_err,
    input  enable, cnt_clr, data_samp_en,
    input  strt_chk_en, deser_en, par_chk_en, stp_chk_en,
    input  data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl_fsm.sv
// uart_rx_ctrl_fsm: UART receiver frame sequencer (start, data, parity, stop).
// Define UART_RX_PARITY_EN to build the optional parity-bit state.
module uart_rx_ctrl_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5,
  parameter int BITCNT_W   = 4
) (
  input logic CLK,
  input logic RST,
  uart_rx_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state_q, state_d;
  logic   last, data_last;
  logic   par_err_q, data_valid_q, frame_err_q;
  logic   enable, cnt_clr, samp;
  logic   strt_chk, deser, par_chk, stp_chk;

`ifdef UART_RX_PARITY_EN
  logic par_q;
`else
  logic unused_par;
  assign unused_par = ^{bus.PAR_EN, bus.par_err};
`endif

  assign last      = bus.edge_cnt == (bus.Prescale - PRESC_W'(1));
  assign data_last = bus.bit_cnt == BITCNT_W'(DATA_WIDTH);

  always_comb begin
    state_d  = state_q;
    enable   = 1'b1;
    samp     = 1'b1;
    cnt_clr  = 1'b0;
    strt_chk = 1'b0;
    deser    = 1'b0;
    par_chk  = 1'b0;
    stp_chk  = 1'b0;
    unique case (state_q)
      IDLE: begin
        enable  = 1'b0;
        samp    = 1'b0;
        cnt_clr = 1'b1;
        if (!bus.RX_IN) state_d = START;
      end
      START: begin
        strt_chk = last;
        if (last) state_d = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser = last;
        if (last && data_last) begin
`ifdef UART_RX_PARITY_EN
          state_d = par_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_chk = last;
        if (last) state_d = STOP;
      end
`endif
      STOP: begin
        stp_chk = last;
        if (last) begin
          // a low line here is the next start bit: restart counters now
          if (!bus.RX_IN) begin
            state_d = START;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        enable  = 1'b0;
        samp    = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      par_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == IDLE && !bus.RX_IN) begin
        par_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_q     <= bus.PAR_EN;
`endif
      end
`ifdef UART_RX_PARITY_EN
      if (state_q == PARITY && last) par_err_q <= bus.par_err;
`endif
      if (state_q == STOP && last) begin
        data_valid_q <= ~(par_err_q | bus.stp_err);
        frame_err_q  <= par_err_q | bus.stp_err;
      end
    end
  end

  assign bus.enable       = enable;
  assign bus.cnt_clr      = cnt_clr;
  assign bus.data_samp_en = samp;
  assign bus.strt_chk_en  = strt_chk;
  assign bus.deser_en     = deser;
  assign bus.par_chk_en   = par_chk;
  assign bus.stp_chk_en   = stp_chk;
  assign bus.data_valid   = data_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = state_q != IDLE;

endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// tb_uart_rx_ctrl_fsm: frame-level scoreboard bench for the UART RX controller.
// Builds with or without UART_RX_PARITY_EN; the frame model follows the macro.
module tb_uart_rx_ctrl_fsm;
  localparam int PW = 5;
  localparam int BW = 4;
  localparam int DW = 8;

  typedef struct {
    bit          err;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          deser_n = 0;
  bit          par_q_m = 1'b0;
  exp_t        q[$];

  uart_rx_ctrl_fsm_if #(.PRESC_W(PW), .BITCNT_W(BW)) bus ();

  uart_rx_ctrl_fsm #(
    .DATA_WIDTH(DW),
    .PRESC_W(PW),
    .BITCNT_W(BW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // edge/bit counter the controller steers
  always @(posedge clk) begin
    if (rst || bus.cnt_clr || !bus.enable) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= '0;
    end else if (bus.edge_cnt == bus.Prescale - 5'd1) begin
      bus.edge_cnt <= '0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // monitor: strobe placement and pulse scoreboard
  always @(negedge clk) begin
    if (rst) begin
      deser_n = 0;
    end else begin
      if (bus.deser_en) deser_n++;
      if (bus.strt_chk_en | bus.deser_en | bus.par_chk_en | bus.stp_chk_en) begin
        check("strobe_at_last", 32'(bus.edge_cnt), 32'(bus.Prescale - 5'd1));
        check("strobe_onehot", $countones({bus.strt_chk_en, bus.deser_en,
              bus.par_chk_en, bus.stp_chk_en}), 1);
      end
`ifndef UART_RX_PARITY_EN
      check("par_chk_tied", 32'(bus.par_chk_en), 0);
`endif
      if (bus.data_valid || bus.frame_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: dv=%0b fe=%0b at cycle %0d, none expected",
                   bus.data_valid, bus.frame_err, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_cycle", cyc, e.at);
          check("frame_err", 32'(bus.frame_err), 32'(e.err));
          check("data_valid", 32'(bus.data_valid), 32'(!e.err));
          check("deser_count", deser_n, DW);
          deser_n = 0;
        end
      end
    end
  end

  // one frame; entered and left #1 after a posedge
  task automatic frame(input int p, input bit par_en, input bit gl,
                       input bit pe, input bit se, input bit chain_in,
                       input bit chain_out, input logic [7:0] data);
    int unsigned e0;
    int          nb;
    int          b;
    bit          par_eff;
    bit          v;
    exp_t        e;
    if (!chain_in) begin
      bus.Prescale = 5'(p);
      bus.PAR_EN   = par_en;
      bus.RX_IN    = 1'b0;
      @(posedge clk); #1;
      par_q_m = par_en;
    end
    e0 = cyc;
    bus.strt_glitch = gl;
    bus.par_err     = pe;
    bus.stp_err     = se;
    if (gl) begin
      @(posedge clk); #1;
      bus.RX_IN = 1'b1;
      repeat (p - 1) @(posedge clk);
      #1;
      check("glitch_idle", 32'(bus.busy), 0);
    end else begin
`ifdef UART_RX_PARITY_EN
      par_eff = par_q_m;
`else
      par_eff = 1'b0;
`endif
      nb    = 10 + int'(par_eff);
      e.err = (par_eff && pe) || se;
      e.at  = e0 + nb * p;
      q.push_back(e);
      for (int k = 1; k <= nb * p; k++) begin
        b = (k - 1) / p;
        if (b == 0) v = 1'b0;
        else if (b <= DW) v = data[b-1];
        else if (par_eff && b == DW + 1) v = ^data;
        else v = 1'b1;
        if (k == nb * p && chain_out) v = 1'b0;
        bus.RX_IN = v;
        if (k == 3 * p) bus.PAR_EN = 1'($urandom);
        if (k == nb * p) begin
          @(negedge clk);
          check("stop_cnt_clr", 32'(bus.cnt_clr), 32'(chain_out));
        end
        @(posedge clk); #1;
      end
      check("post_frame_busy", 32'(bus.busy), 32'(chain_out));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit chain;
    int p;
    bus.RX_IN       = 1'b1;
    bus.Prescale    = 5'd8;
    bus.PAR_EN      = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cnt_clr", 32'(bus.cnt_clr), 1);
    check("rst_enable", 32'(bus.enable), 0);
    check("rst_samp", 32'(bus.data_samp_en), 0);
    check("rst_dv_fe", 32'({bus.data_valid, bus.frame_err}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", 32'(bus.busy), 0);

    frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    repeat (2) @(posedge clk);
    #1;
    frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    repeat (2) @(posedge clk);
    #1;
    frame(8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    repeat (2) @(posedge clk);
    #1;
    frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    frame(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-DATA aborts the frame
    bus.Prescale    = 5'd8;
    bus.strt_glitch = 1'b0;
    bus.RX_IN       = 1'b0;
    @(posedge clk); #1;
    bus.RX_IN = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_cnt_clr", 32'(bus.cnt_clr), 1);
    check("midrst_dv_fe", 32'({bus.data_valid, bus.frame_err}), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle", 32'(bus.busy), 0);

    chain = 1'b0;
    p = 8;
    for (int i = 0; i < 40; i++) begin
      bit gl;
      bit co;
      if (!chain) p = $urandom_range(0, 1) ? 16 : 8;
      gl = $urandom_range(0, 5) == 0;
      co = !gl && i != 39 && $urandom_range(0, 2) == 0;
      frame(p, 1'($urandom), gl, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, chain, co, 8'($urandom));
      chain = co;
      if (!co) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_frames", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
